// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_pkg
//  Description : Shared sizes, output-stage state type and one-hot helper for
//                the registered 8-to-3 priority event encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package prio_enc_pkg;

    localparam int N_IN   = 8;
    localparam int CODE_W = 3;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [N_IN-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [N_IN-1:0] mask;
        mask       = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

endpackage : prio_enc_pkg
`default_nettype wire

// File: rtl/prio_enc8.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc8
//  Description : Combinational 8-bit priority encoder; highest set index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc8
    import prio_enc_pkg::*;
(
    input  logic [N_IN-1:0]   vec_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              any_o
);

    // Ascending scan: later (higher) set bits overwrite earlier ones.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (vec_i[i]) begin
                idx_o = CODE_W'(i);
            end
        end
        any_o = |vec_i;
    end

endmodule : prio_enc8
`default_nettype wire

// File: rtl/prio_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : prio_event_encoder
//  Description : Captures rising edges on eight request lines as pending
//                events and delivers the highest one as {a,b,c} via valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_event_encoder
    import prio_enc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            e,
    input  logic [N_IN-1:0] d,
    input  logic            ready,
    input  logic            clr_ovf,
    output logic            a,
    output logic            b,
    output logic            c,
    output logic            valid,
    output logic [N_IN-1:0] pending,
    output logic            ovf
);

    logic [N_IN-1:0]   d_q;
    logic [N_IN-1:0]   pending_q;
    logic [N_IN-1:0]   pending_d;
    logic [CODE_W-1:0] code_q;
    logic              ovf_q;
    state_t            state_q;

    logic [N_IN-1:0]   w_rise;
    logic [N_IN-1:0]   w_clr_mask;
    logic [N_IN-1:0]   w_pend_rem;
    logic              w_accept;
    logic              w_ovf_set;
    logic [CODE_W-1:0] w_idx_pend;
    logic [CODE_W-1:0] w_idx_rem;
    logic              w_any_pend;
    logic              w_any_rem;

    // A rise on a bit being cleared this cycle is a fresh event, not a loss.
    always_comb begin
        w_rise     = d & ~d_q;
        w_accept   = (state_q == FULL) && ready;
        w_clr_mask = w_accept ? onehot(code_q) : '0;
        w_pend_rem = pending_q & ~w_clr_mask;
        pending_d  = w_pend_rem | (e ? w_rise : '0);
        w_ovf_set  = e && (|(w_rise & w_pend_rem));
    end

    prio_enc8 u_enc_pend (
        .vec_i (pending_q),
        .idx_o (w_idx_pend),
        .any_o (w_any_pend)
    );

    prio_enc8 u_enc_rem (
        .vec_i (w_pend_rem),
        .idx_o (w_idx_rem),
        .any_o (w_any_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q       <= '0;
            pending_q <= '0;
            code_q    <= '0;
            ovf_q     <= 1'b0;
            state_q   <= EMPTY;
        end else begin
            d_q       <= d;
            pending_q <= pending_d;

            if (w_ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end

            case (state_q)
                EMPTY: begin
                    if (e && w_any_pend) begin
                        code_q  <= w_idx_pend;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (ready) begin
                        if (e && w_any_rem) begin
                            code_q <= w_idx_rem;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign {a, b, c} = code_q;
    assign valid     = (state_q == FULL);
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule : prio_event_encoder
`default_nettype wire

// File: tb/tb_prio_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_event_encoder
//  Description : Directed and random checks of prio_event_encoder against an
//                event-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_event_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       e;
    logic [7:0] d;
    logic       ready;
    logic       clr_ovf;
    logic       a, b, c;
    logic       valid;
    logic [7:0] pending;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: which events are outstanding and what is shown.
    bit [7:0] m_pend;
    bit       m_valid;
    int       m_code;
    bit       m_ovf;
    bit [7:0] m_dprev;

    prio_event_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .e       (e),
        .d       (d),
        .ready   (ready),
        .clr_ovf (clr_ovf),
        .a       (a),
        .b       (b),
        .c       (c),
        .valid   (valid),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    function automatic int highest(input bit [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_code  = 0;
        m_ovf   = 1'b0;
        m_dprev = '0;
    endtask

    task automatic model_step();
        bit [7:0] nxt;
        bit [7:0] rem;
        bit       acc;
        bit       lost;
        acc  = m_valid && ready;
        nxt  = m_pend;
        if (acc) nxt[m_code] = 1'b0;
        rem  = nxt;
        lost = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (e && d[i] && !m_dprev[i]) begin
                if (rem[i]) lost = 1'b1;
                nxt[i] = 1'b1;
            end
        end
        if (lost) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (!m_valid) begin
            if (e && m_pend != 0) begin
                m_code  = highest(m_pend);
                m_valid = 1'b1;
            end
        end else if (ready) begin
            if (e && rem != 0) m_code = highest(rem);
            else m_valid = 1'b0;
        end
        m_pend  = nxt;
        m_dprev = d;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", {7'd0, valid}, {7'd0, m_valid});
        chk("pending", pending, m_pend);
        chk("ovf", {7'd0, ovf}, {7'd0, m_ovf});
        if (m_valid) chk("code", {5'd0, a, b, c}, 8'(m_code));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        rst_n = 1'b0; e = 1'b1; d = '0; ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {a, b, c, valid, ovf, 3'd0}, 8'h00);
        chk("reset_pending", pending, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pulse: pending after one edge, code 5 after two, then held.
        cyc();
        d = 8'h20;
        cyc();
        chk("pulse_pending", pending, 8'h20);
        chk("pulse_not_valid_yet", {7'd0, valid}, 8'h00);
        d = 8'h00;
        cyc();
        chk("pulse_code", {4'd0, valid, a, b, c}, 8'h0D);
        repeat (5) cyc();
        chk("pulse_held", {4'd0, valid, a, b, c}, 8'h0D);
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        cyc();

        // Two simultaneous events drained back-to-back.
        d = 8'h81; ready = 1'b1;
        cyc();
        cyc();
        chk("b2b_first", {4'd0, valid, a, b, c}, 8'h0F);
        cyc();
        chk("b2b_second", {4'd0, valid, a, b, c}, 8'h08);
        cyc();
        chk("b2b_empty", {valid, 7'd0}, 8'h00);
        chk("b2b_pend_clear", pending, 8'h00);
        d = 8'h00;

        // Level held high yields exactly one event.
        d = 8'h04;
        repeat (10) cyc();
        chk("level_once", pending, 8'h00);
        d = 8'h00; ready = 1'b0;
        cyc();

        // Repeated pulse on a still-pending bit sets ovf; clr_ovf clears it.
        d = 8'h08; cyc(); d = 8'h00; cyc(); cyc(); cyc();
        d = 8'h08; cyc(); d = 8'h00; cyc();
        chk("ovf_set", {7'd0, ovf}, 8'h01);
        chk("ovf_pending", pending, 8'h08);
        clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
        chk("ovf_cleared", {7'd0, ovf}, 8'h00);
        ready = 1'b1; cyc(); ready = 1'b0; cyc();

        // Edges while disabled are lost for good.
        e = 1'b0; d = 8'hFF;
        repeat (3) cyc();
        e = 1'b1;
        repeat (3) cyc();
        chk("disabled_pending", pending, 8'h00);
        chk("disabled_valid", {7'd0, valid}, 8'h00);
        d = 8'h00;
        cyc();

        // Asynchronous reset while code 3 is on offer.
        d = 8'h08; cyc(); d = 8'h00; cyc();
        chk("pre_reset_code", {4'd0, valid, a, b, c}, 8'h0B);
        ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", {a, b, c, valid, ovf, 3'd0}, 8'h00);
        chk("async_reset_pend", pending, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            d       = d ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            e       = ($urandom_range(0, 9) != 0);
            ready   = ($urandom_range(0, 2) != 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_prio_event_encoder
`default_nettype wire

// File: doc/prio_event_encoder.md
Name: prio_event_encoder

Overview:
- Registered 8-to-3 priority encoder with event capture. It is the inverse of the lab's 3-to-8 enabled decoder.
- Detects rising edges on eight request lines and latches them as pending events.
- Presents the highest-priority pending event as a 3-bit code {a,b,c} with a valid/ready handshake.
- Sits between external event sources (switches, peripherals) and a consumer, e.g. the decoder driving LEDs.

Parameters:
- N_IN, 8, number of request lines. Fixed at 8 for this revision.
- CODE_W, 3, code width. Equals clog2(N_IN).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- e  in  1  enable; gates event capture and code loading
- d  in  8  request lines; d[7] highest priority, d[0] lowest
- ready  in  1  consumer accepts the current code
- clr_ovf  in  1  synchronous clear of ovf
- a  out  1  code MSB (code[2])
- b  out  1  code[1]
- c  out  1  code LSB (code[0])
- valid  out  1  {a,b,c} holds an undelivered event
- pending  out  8  registered pending-event vector (status)
- ovf  out  1  sticky: an event was lost

Behaviour:
- Reset (rst_n=0, async):
  - a=b=c=0, valid=0, pending=0, ovf=0.
  - Internal d_q=0, so any d bit high at reset release is captured as an edge on the first clock.
- Edge detect:
  - rise = d & ~d_q.
  - d_q <= d every cycle, regardless of e.
- Capture (e=1):
  - pending <= (pending & ~clr_mask) | rise.
  - While e=0, rise is discarded; no capture.
- Output stage, two states:
  - EMPTY (valid=0): if e=1 and pending!=0, load {a,b,c} = index of the highest set bit of pending, set valid=1, go to FULL.
  - FULL (valid=1): {a,b,c} and valid stay stable while ready=0.
  - On ready=1: clr_mask = one-hot of the current code. In the same cycle, if e=1 and (pending & ~clr_mask)!=0, reload with the next highest index and stay FULL. Otherwise go to EMPTY.
  - ready while valid=0 is ignored.
- Loading uses the registered pending only. An edge arriving in cycle N becomes pending at edge N and is presented at the earliest at edge N+1 (2-cycle latency from d to valid).
- Back-to-back: with a sustained ready=1, one code is delivered per cycle.
- The delivered code's pending bit clears exactly at the accept edge.
- Simultaneous set and clear of the same bit: rise wins, and the bit stays pending (a new event).
- Overflow: ovf <= 1 when e=1 and rise[i]=1 while pending[i]=1 and bit i is not being cleared that cycle. The event merges, so the count is lost.
  - ovf clears only on clr_ovf=1.
  - When a set and a clear of ovf happen in the same cycle, set wins.
- e=0 while FULL:
  - The held code remains valid and can still be accepted (clearing its bit).
  - No reload occurs; the stage then goes to EMPTY.
- Reset mid-operation: everything clears immediately; in-flight and pending events are discarded.

Decomposition:
- Package prio_enc_pkg: N_IN, CODE_W, the state enum {EMPTY, FULL}, and a function onehot(code) returning the 8-bit mask.
- Sub-module prio_enc8: pure combinational, 8-bit vector in, 3-bit index plus any-set flag out, highest index wins.
  - Instantiated twice: once on pending, once on pending & ~clr_mask.

Test Plan:
- Reset release with d=8'h00, then pulse d=8'h20 one cycle (e=1, ready=0) -> pending=8'h20 after 1 edge; valid=1, {a,b,c}=3'b101 after 2 edges; held stable for 5 cycles.
- d rises to 8'h81 in one cycle, then ready=1 held -> codes 3'b111 then 3'b000 on consecutive cycles; valid=0 and pending=0 on the third cycle.
- d held high at 8'h04 for 10 cycles -> exactly one event (code 3'b010); no re-capture after accept.
- Pulse d[3] twice, 3 cycles apart, with ready=0 -> ovf=1, pending=8'h08; one clr_ovf pulse -> ovf=0.
- e=0 and pulse d=8'hFF -> pending stays 0, valid stays 0; set e=1 -> still nothing, because the edges were discarded.
- With valid=1 holding code 3'b011, assert rst_n=0 mid-handshake -> all outputs 0 asynchronously, before the next clk edge.
